zircon_avalon_pwm_multi_logic: RTL

- Multi-channel PWM generator; parametrised successor of the single-channel buzzer PWM logic.
- Adds a shared clock prescaler, double-buffered period/duty (glitch-free update at period boundary), per-channel output polarity, and a burst mode that emits N periods then stops with a done pulse.
- Sits behind the Avalon-MM register slave: the slave drives the configuration inputs, and coe_pwm goes to pins (buzzers, LEDs, motor drivers).

---
 rtl/zircon_avalon_pwm_multi_logic_pkg.sv | 15 +
 rtl/zircon_avalon_pwm_multi_logic_channel.sv | 124 ++++++++++++
 rtl/zircon_avalon_pwm_multi_logic.sv | 58 +++++
 3 files changed

// File: rtl/zircon_avalon_pwm_multi_logic_pkg.sv
// Shared definitions for the multi-channel PWM: channel state encoding and default sizes.
package zircon_avalon_pwm_multi_logic_pkg;

  localparam int unsigned PWM_CH_NUM_DEF  = 4;
  localparam int unsigned PWM_CNT_W_DEF   = 32;
  localparam int unsigned PWM_PRESC_W_DEF = 16;
  localparam int unsigned PWM_BURST_W_DEF = 16;

  typedef enum logic [1:0] {
    PWM_IDLE = 2'd0,
    PWM_RUN  = 2'd1,
    PWM_STOP = 2'd2
  } pwm_state_e;

endpackage

// File: rtl/zircon_avalon_pwm_multi_logic_channel.sv
// One PWM channel: FSM, period counter, shadow period/duty buffer, burst counter, output flop.
module zircon_pwm_channel
  import zircon_avalon_pwm_multi_logic_pkg::*;
#(
  parameter int unsigned CNT_W   = PWM_CNT_W_DEF,
  parameter int unsigned BURST_W = PWM_BURST_W_DEF
) (
  input  logic               csi_clk,
  input  logic               rsi_reset_n,
  input  logic               tick,
  input  logic               enable,
  input  logic               polarity,
  input  logic               load,
  input  logic               burst_mode,
  input  logic [CNT_W-1:0]   period,
  input  logic [CNT_W-1:0]   duty,
  input  logic [BURST_W-1:0] burst_len,
  output logic               coe_pwm,
  output logic               busy,
  output logic               done
);

  pwm_state_e         state;
  logic               en_q;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   act_period;
  logic [CNT_W-1:0]   act_duty;
  logic [CNT_W-1:0]   pend_period;
  logic [CNT_W-1:0]   pend_duty;
  logic               pend_valid;
  logic [BURST_W-1:0] burst_cnt;
  logic [BURST_W-1:0] burst_lim;
  logic               wrap;
  logic               burst_end;
  logic [BURST_W:0]   burst_next;

  // burst_end is evaluated regardless of enable so done still fires when enable drops on the final wrap
  always_comb begin
    wrap       = tick && (cnt >= act_period);
    burst_next = {1'b0, burst_cnt} + {{BURST_W{1'b0}}, 1'b1};
    burst_end  = (state == PWM_RUN) && wrap && burst_mode && (burst_lim != '0) &&
                 (burst_next >= {1'b0, burst_lim});
  end

  assign busy = (state == PWM_RUN);

  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) begin
      state       <= PWM_IDLE;
      en_q        <= 1'b0;
      cnt         <= '0;
      act_period  <= '0;
      act_duty    <= '0;
      pend_period <= '0;
      pend_duty   <= '0;
      pend_valid  <= 1'b0;
      burst_cnt   <= '0;
      burst_lim   <= '0;
      coe_pwm     <= 1'b0;
      done        <= 1'b0;
    end else begin
      en_q <= enable;
      done <= burst_end;
      if (!enable) begin
        state   <= PWM_IDLE;
        cnt     <= '0;
        coe_pwm <= polarity;
        if (load) begin
          act_period <= period;
          act_duty   <= duty;
        end
      end else begin
        coe_pwm <= (state == PWM_RUN) ? ((cnt < act_duty) ^ polarity) : polarity;
        case (state)
          PWM_IDLE: begin
            if (!en_q) begin
              state      <= PWM_RUN;
              cnt        <= '0;
              act_period <= period;
              act_duty   <= duty;
              pend_valid <= 1'b0;
              burst_cnt  <= '0;
              burst_lim  <= burst_len;
            end else if (load) begin
              act_period <= period;
              act_duty   <= duty;
            end
          end
          PWM_RUN: begin
            if (wrap) begin
              cnt <= '0;
              if (burst_cnt != '1) burst_cnt <= burst_next[BURST_W-1:0];
              // a load coinciding with the wrap bypasses the pending buffer
              if (load) begin
                act_period <= period;
                act_duty   <= duty;
              end else if (pend_valid) begin
                act_period <= pend_period;
                act_duty   <= pend_duty;
              end
              pend_valid <= 1'b0;
              if (burst_end) state <= PWM_STOP;
            end else begin
              if (tick) cnt <= cnt + CNT_W'(1);
              if (load) begin
                pend_period <= period;
                pend_duty   <= duty;
                pend_valid  <= 1'b1;
              end
            end
          end
          PWM_STOP: begin
            if (load) begin
              act_period <= period;
              act_duty   <= duty;
            end
          end
          default: state <= PWM_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/zircon_avalon_pwm_multi_logic.sv
// Multi-channel PWM generator: shared prescaler tick feeding CH_NUM independent channels.
module zircon_avalon_pwm_multi_logic
  import zircon_avalon_pwm_multi_logic_pkg::*;
#(
  parameter int unsigned CH_NUM  = PWM_CH_NUM_DEF,
  parameter int unsigned CNT_W   = PWM_CNT_W_DEF,
  parameter int unsigned PRESC_W = PWM_PRESC_W_DEF,
  parameter int unsigned BURST_W = PWM_BURST_W_DEF
) (
  input  logic                      csi_clk,
  input  logic                      rsi_reset_n,
  input  logic [PRESC_W-1:0]        pwm_prescale,
  input  logic [CH_NUM-1:0]         pwm_enable,
  input  logic [CH_NUM*CNT_W-1:0]   pwm_period,
  input  logic [CH_NUM*CNT_W-1:0]   pwm_duty,
  input  logic [CH_NUM-1:0]         pwm_polarity,
  input  logic [CH_NUM-1:0]         pwm_load,
  input  logic [CH_NUM-1:0]         pwm_burst_mode,
  input  logic [CH_NUM*BURST_W-1:0] pwm_burst_len,
  output logic [CH_NUM-1:0]         coe_pwm,
  output logic [CH_NUM-1:0]         pwm_busy,
  output logic [CH_NUM-1:0]         pwm_done
);

  logic [PRESC_W-1:0] presc_cnt;
  logic               tick;

  // >= so that lowering the prescale value never forces a full counter wrap
  always_comb tick = (presc_cnt >= pwm_prescale);

  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) presc_cnt <= '0;
    else if (tick)    presc_cnt <= '0;
    else              presc_cnt <= presc_cnt + PRESC_W'(1);
  end

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    zircon_pwm_channel #(
      .CNT_W   (CNT_W),
      .BURST_W (BURST_W)
    ) u_ch (
      .csi_clk     (csi_clk),
      .rsi_reset_n (rsi_reset_n),
      .tick        (tick),
      .enable      (pwm_enable[i]),
      .polarity    (pwm_polarity[i]),
      .load        (pwm_load[i]),
      .burst_mode  (pwm_burst_mode[i]),
      .period      (pwm_period[i*CNT_W +: CNT_W]),
      .duty        (pwm_duty[i*CNT_W +: CNT_W]),
      .burst_len   (pwm_burst_len[i*BURST_W +: BURST_W]),
      .coe_pwm     (coe_pwm[i]),
      .busy        (pwm_busy[i]),
      .done        (pwm_done[i])
    );
  end

endmodule
